fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Downstream drain stage for the synchronous FIFO: pops one byte at a time through the FIFO read port and transmits it as an asynchronous serial frame (start bit, LSB-first data, optional parity, stop bit) on a single `tx` line. It is the only consumer of the FIFO read side in the serial output path. Frames are sent back-to-back for as long as the FIFO is non-empty.

## Interface
- `DATA_WIDTH`, 8: width of the FIFO word and of the serial data field.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; must be ≥ 2.
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-low. `reset=0` at a rising edge resets the block.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_data`  in  DATA_WIDTH: FIFO `data_out`. Registered by the FIFO and valid in the cycle after the edge that sampled `rd_en=1`.
- `fifo_rd_en`  out  1: FIFO `rd_en`.
- `tx`  out  1: serial line; idles high.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- Reset values:
  - `tx=1`, `fifo_rd_en=0`, `busy=0`.
  - State is IDLE; baud counter, bit counter and shift register are 0.
- States: IDLE → FETCH → WAIT → START → DATA → [PARITY] → STOP → (FETCH or IDLE).
- IDLE: if `fifo_empty=0` at the edge, go to FETCH. Otherwise stay in IDLE.
- FETCH: lasts 1 cycle. `fifo_rd_en=1` is a Moore output of this state only; exactly one pop per frame.
- WAIT: lasts 1 cycle. At the closing edge, `fifo_data` is latched into the shift register.
- START: `tx=0` for CLKS_PER_BIT cycles.
- DATA: `tx` = shift register bit 0, LSB first. Shift right every CLKS_PER_BIT cycles; DATA_WIDTH bits total.
- Counters:
  - Bit counter is clog2(DATA_WIDTH) bits wide and exits DATA at DATA_WIDTH-1.
  - Baud counter is clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1 and clears on every state change.
- PARITY: present only when the parity feature is compiled in (see Configuration).
- STOP: `tx=1` for CLKS_PER_BIT cycles. At the last cycle:
  - `fifo_empty=0` → go to FETCH (no IDLE cycle);
  - otherwise → go to IDLE.
- Empty FIFO: `fifo_rd_en` is never asserted while `fifo_empty=1` in IDLE/STOP. The block never underflows the FIFO.
- `fifo_full` is not observed; back-pressure to writers is the FIFO's concern.
- Reset mid-frame: on the next edge, `tx=1` and the state is IDLE. The popped byte is discarded and not retransmitted.
- `fifo_data` is ignored outside WAIT. `fifo_empty` is ignored outside IDLE and the final STOP cycle.

## Timing
- Edge N samples `fifo_empty=0` in IDLE:
  - `fifo_rd_en=1` during cycle N..N+1;
  - data latched at edge N+2;
  - `tx` falls at edge N+2.
- Frame length: (DATA_WIDTH+2)·CLKS_PER_BIT cycles, or (DATA_WIDTH+3)·CLKS_PER_BIT with parity.
- Back-to-back frames: stop bit lasts CLKS_PER_BIT+2 cycles (the FETCH and WAIT cycles hold `tx=1`).
- `busy` rises at the edge entering FETCH and falls at the edge entering IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `FIFO_UART_TX_PARITY_EN`.
- Defined:
  - A PARITY state of CLKS_PER_BIT cycles is inserted between DATA and STOP.
  - `tx` = XOR of the DATA_WIDTH data bits (even parity).
- Undefined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.
- All other behaviour is identical in both builds.

## Test plan
- Single byte `0x55`, CLKS_PER_BIT=16, no parity:
  - one `fifo_rd_en` pulse;
  - `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles;
  - `busy` high for 162 cycles, then IDLE with `tx=1`.
- FIFO held empty for 500 cycles after reset → `fifo_rd_en=0` and `tx=1` throughout.
- Three bytes `0x01,0x80,0xFF` preloaded:
  - three `fifo_rd_en` pulses;
  - frames decode to the same values in order;
  - inter-frame high time 18 cycles;
  - `busy` stays high until the third stop bit completes.
- Reset asserted (`reset=0`) at bit 3 of byte `0xA5`:
  - next edge gives `tx=1`, `busy=0`, `fifo_rd_en=0`;
  - after release, the next FIFO byte is sent in full and `0xA5` is not resent.
- With `FIFO_UART_TX_PARITY_EN`, byte `0x07`:
  - parity bit = 1; frame is 176 cycles.
  - Byte `0x03` gives parity bit = 0.
- Simultaneous event: `fifo_empty` falls exactly in the last STOP cycle → FETCH on the next edge with no IDLE cycle, and `busy` never drops.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time onto an idle-high UART tx line.
// Define FIFO_UART_TX_PARITY_EN to append an even-parity bit to every frame.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           baud_q, baud_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    rd_en_q, rd_en_d;
    logic                    busy_q, busy_d;
    logic                    baud_last;
    logic                    timed;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = FETCH;
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                state_d = START;
                shift_d = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^fifo_data;
`endif
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) state_d = STOP;
            end
`endif
            STOP: begin
                // Chain straight into the next pop when more data waits.
                if (baud_last) state_d = fifo_empty ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        timed = (state_q == START) || (state_q == DATA)
             || (state_q == STOP);
`ifdef FIFO_UART_TX_PARITY_EN
        timed = timed || (state_q == PARITY);
`endif
        baud_d = '0;
        if (timed && (state_d == state_q) && !baud_last)
            baud_d = baud_q + 1'b1;
    end

    always_comb begin
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        rd_en_d = (state_d == FETCH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeds bytes, a UART monitor decodes tx
// and compares each frame against a scoreboard of bytes pushed by stimulus.
module tb_fifo_uart_tx;
    localparam int DW  = 8;
    localparam int CPB = 16;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = DW + 3;
`else
    localparam int FRAME_BITS = DW + 2;
`endif
    localparam int BUSY1 = FRAME_BITS * CPB + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb[$];
    int            gap_q[$];
    logic          hold_empty = 1'b0;
    logic          data_pend = 1'b0;
    logic [DW-1:0] pop_val = '0;
    int            rd_pulses = 0;

    // Registered-read FIFO: data appears only in the cycle after the pop.
    always @(negedge clk) begin
        if (data_pend) begin
            fifo_data = pop_val;
            data_pend = 1'b0;
        end else begin
            fifo_data = DW'($urandom);
        end
        if (fifo_rd_en) begin
            rd_pulses++;
            chk("rd_nonempty", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) begin
                pop_val   = fifo_q.pop_front();
                data_pend = 1'b1;
            end
        end
        fifo_empty = hold_empty || (fifo_q.size() == 0);
    end

    logic                  mon_on = 1'b0;
    logic                  mok = 1'b1;
    logic [FRAME_BITS-1:0] fv = '0;
    int                    mcnt = 0;
    int                    idle_hi = 0;
    int                    frames_rx = 0;
    logic                  last_par = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            mon_on = 1'b0;
        end else if (!mon_on && tx == 1'b0) begin
            mon_on = 1'b1;
            mcnt   = 0;
            mok    = 1'b1;
            gap_q.push_back(idle_hi);
            idle_hi = 0;
        end else if (!mon_on) begin
            idle_hi++;
        end
        if (mon_on) begin
            if (mcnt % CPB == 0) fv[mcnt / CPB] = tx;
            else if (tx != fv[mcnt / CPB]) mok = 1'b0;
            mcnt++;
            if (mcnt == FRAME_BITS * CPB) begin
                mon_on  = 1'b0;
                idle_hi = CPB;
                chk("stop_bit", fv[FRAME_BITS-1], 1);
                chk("bit_timing", mok, 1);
`ifdef FIFO_UART_TX_PARITY_EN
                last_par = fv[DW+1];
                chk("parity", fv[DW+1], ^fv[DW:1]);
`endif
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) chk("rx_byte", fv[DW:1], sb.pop_front());
                frames_rx++;
            end
        end
    end

    int busy_run = 0;
    int last_busy = 0;
    int busy_falls = 0;

    always @(negedge clk) begin
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
            busy_falls++;
        end
    end

    task automatic send(input logic [DW-1:0] b, input bit exp_rx = 1'b1);
        fifo_q.push_back(b);
        if (exp_rx) sb.push_back(b);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int target = frames_rx + n;
        int k = 0;
        while ((frames_rx < target || busy) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("frames_done", (frames_rx >= target) && !busy, 1);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tx(input logic v);
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (tx != v && k < 400);
        chk("tx_edge", tx, v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rd0, bf0, viol;

    initial begin
        repeat (3) step();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd", fifo_rd_en, 0);
        reset = 1'b1;

        viol = 0;
        repeat (500) begin
            step();
            if (fifo_rd_en || !tx || busy) viol++;
        end
        chk("idle_empty", viol, 0);

        // Single byte: latency of pop and start bit, then full frame.
        rd0 = rd_pulses;
        bf0 = busy_falls;
        send(8'h55);
        step();
        chk("lat_rd", fifo_rd_en, 1);
        chk("lat_busy", busy, 1);
        chk("lat_tx_fetch", tx, 1);
        step();
        chk("lat_rd_wait", fifo_rd_en, 0);
        chk("lat_tx_wait", tx, 1);
        step();
        chk("lat_tx_start", tx, 0);
        wait_frames(1, 400);
        chk("one_pop", rd_pulses - rd0, 1);
        chk("busy_len1", last_busy, BUSY1);
        chk("busy_falls1", busy_falls - bf0, 1);
        chk("tx_idle1", tx, 1);

        rd0 = rd_pulses;
        bf0 = busy_falls;
        gap_q.delete();
        send(8'h01);
        send(8'h80);
        send(8'hFF);
        wait_frames(3, 3 * BUSY1 + 50);
        chk("three_pops", rd_pulses - rd0, 3);
        chk("busy_len3", last_busy, 3 * BUSY1);
        chk("busy_falls3", busy_falls - bf0, 1);
        chk("gap_cnt", gap_q.size(), 3);
        if (gap_q.size() == 3) begin
            chk("gap1", gap_q[1], CPB + 2);
            chk("gap2", gap_q[2], CPB + 2);
        end

        // Data appears exactly in the last STOP cycle.
        rd0 = rd_pulses;
        bf0 = busy_falls;
        gap_q.delete();
        send(8'h00);
        wait_tx(1'b0);
        hold_empty = 1'b1;
        send(8'h5A);
        wait_tx(1'b1);
        repeat (15) step();
        chk("late_busy", busy, 1);
        chk("late_rd", fifo_rd_en, 0);
        hold_empty = 1'b0;
        step();
        chk("late_fetch", fifo_rd_en, 1);
        chk("late_busy2", busy, 1);
        wait_frames(1, BUSY1 + 50);
        chk("late_pops", rd_pulses - rd0, 2);
        chk("late_falls", busy_falls - bf0, 1);
        chk("late_len", last_busy, 2 * BUSY1);
        if (gap_q.size() != 0) chk("late_gap", gap_q[$], CPB + 2);

        // Reset in the middle of data bit 3 of 0xA5.
        rd0 = rd_pulses;
        send(8'hA5, 1'b0);
        wait_tx(1'b0);
        repeat (4 * CPB + 8) step();
        chk("mid_bit3", tx, 0);
        reset = 1'b0;
        step();
        chk("mrst_tx", tx, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_rd", fifo_rd_en, 0);
        send(8'h3C);
        step();
        reset = 1'b1;
        wait_frames(1, BUSY1 + 50);
        chk("mrst_pops", rd_pulses - rd0, 2);

`ifdef FIFO_UART_TX_PARITY_EN
        send(8'h07);
        wait_frames(1, BUSY1 + 50);
        chk("par_07", last_par, 1);
        chk("par_len", last_busy, BUSY1);
        send(8'h03);
        wait_frames(1, BUSY1 + 50);
        chk("par_03", last_par, 0);
`endif

        repeat (5) step();
        chk("sb_drained", sb.size(), 0);
        chk("fifo_drained", fifo_q.size(), 0);
        chk("end_tx", tx, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
